// File: rtl/mem_data_arbiter.sv
// mem_data_arbiter: shares the byte-wide block-RAM data port between two requesters,
// round-robin or fixed priority, with a watchdog on the memory done pulse.
module mem_data_arbiter #(
    parameter bit          FIXED_PRIO   = 1'b0,
    parameter int unsigned WAIT_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] m0_addr,
    input  logic [7:0]  m0_wdata,
    input  logic        m0_write,
    input  logic        m0_req,
    output logic [7:0]  m0_rdata,
    output logic        m0_done,
    output logic        m0_err,
    input  logic [15:0] m1_addr,
    input  logic [7:0]  m1_wdata,
    input  logic        m1_write,
    input  logic        m1_req,
    output logic [7:0]  m1_rdata,
    output logic        m1_done,
    output logic        m1_err,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_write,
    output logic        mem_req,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_done,
    output logic        busy,
    output logic        grant
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(WAIT_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        pick;
    logic        done;
    logic        err;
    logic [7:0]  rdata;
    logic [15:0] sel_addr;
    logic [7:0]  sel_wdata;
    logic        sel_write;

    assign sel_addr  = grant_q ? m1_addr  : m0_addr;
    assign sel_wdata = grant_q ? m1_wdata : m0_wdata;
    assign sel_write = grant_q ? m1_write : m0_write;

    // Port 1 wins when alone, or on a round-robin tie after port 0 was served
    assign pick = m1_req & (~m0_req | (~FIXED_PRIO & ~last_grant_q));

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        done         = 1'b0;
        err          = 1'b0;
        rdata        = 8'h00;
        mem_req      = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = m0_addr;
        mem_wdata    = m0_wdata;
        busy         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (m0_req | m1_req) begin
                    state_d      = S_ISSUE;
                    grant_d      = pick;
                    last_grant_d = pick;
                end
            end
            S_ISSUE: begin
                busy      = 1'b1;
                mem_req   = 1'b1;
                mem_write = sel_write;
                mem_addr  = sel_addr;
                mem_wdata = sel_wdata;
                cnt_d     = 8'd0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                busy      = 1'b1;
                mem_addr  = sel_addr;
                mem_wdata = sel_wdata;
                if (mem_done) begin
                    done    = 1'b1;
                    rdata   = mem_rdata;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    done    = 1'b1;
                    err     = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Reset silences every output in the cycle it is asserted
        if (reset) begin
            done      = 1'b0;
            err       = 1'b0;
            rdata     = 8'h00;
            mem_req   = 1'b0;
            mem_write = 1'b0;
            mem_addr  = 16'h0000;
            mem_wdata = 8'h00;
            busy      = 1'b0;
        end
    end

    assign m0_done  = done & ~grant_q;
    assign m1_done  = done & grant_q;
    assign m0_err   = err & ~grant_q;
    assign m1_err   = err & grant_q;
    assign m0_rdata = grant_q ? 8'h00 : rdata;
    assign m1_rdata = grant_q ? rdata : 8'h00;
    assign grant    = grant_q & ~reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_data_arbiter.sv
// tb_mem_data_arbiter: round-robin and fixed-priority arbiters side by side,
// checked every cycle against a transaction-level model plus directed literals.
module tb_mem_data_arbiter;

    localparam int T0 = 15;
    localparam int T1 = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [15:0] a_addr  [2][2];
    logic [7:0]  a_wdata [2][2];
    logic        a_wr    [2][2];
    logic        a_req   [2][2];

    logic [7:0]  mem_rdata [2];
    logic        mem_done  [2];
    logic        withhold  [2];
    logic        inject    [2];
    logic        use_lit   [2];
    logic [7:0]  lit       [2];

    logic [7:0]  rr_m0_rdata, rr_m1_rdata, fp_m0_rdata, fp_m1_rdata;
    logic        rr_m0_done, rr_m1_done, fp_m0_done, fp_m1_done;
    logic        rr_m0_err, rr_m1_err, fp_m0_err, fp_m1_err;
    logic [15:0] rr_mem_addr, fp_mem_addr;
    logic [7:0]  rr_mem_wdata, fp_mem_wdata;
    logic        rr_mem_write, fp_mem_write, rr_mem_req, fp_mem_req;
    logic        rr_busy, fp_busy, rr_grant, fp_grant;

    logic [7:0]  o_rdata [2][2];
    logic        o_done  [2][2];
    logic        o_err   [2][2];
    logic [15:0] o_maddr [2];
    logic [7:0]  o_mwd   [2];
    logic        o_mwr   [2];
    logic        o_mreq  [2];
    logic        o_busy  [2];
    logic        o_grant [2];

    int checks = 0;
    int failures = 0;

    mem_data_arbiter #(.FIXED_PRIO(1'b0), .WAIT_TIMEOUT(T0)) dut_rr (
        .clock(clk), .reset(rst),
        .m0_addr(a_addr[0][0]), .m0_wdata(a_wdata[0][0]), .m0_write(a_wr[0][0]),
        .m0_req(a_req[0][0]), .m0_rdata(rr_m0_rdata), .m0_done(rr_m0_done), .m0_err(rr_m0_err),
        .m1_addr(a_addr[0][1]), .m1_wdata(a_wdata[0][1]), .m1_write(a_wr[0][1]),
        .m1_req(a_req[0][1]), .m1_rdata(rr_m1_rdata), .m1_done(rr_m1_done), .m1_err(rr_m1_err),
        .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata), .mem_write(rr_mem_write),
        .mem_req(rr_mem_req), .mem_rdata(mem_rdata[0]), .mem_done(mem_done[0]),
        .busy(rr_busy), .grant(rr_grant)
    );

    mem_data_arbiter #(.FIXED_PRIO(1'b1), .WAIT_TIMEOUT(T1)) dut_fp (
        .clock(clk), .reset(rst),
        .m0_addr(a_addr[1][0]), .m0_wdata(a_wdata[1][0]), .m0_write(a_wr[1][0]),
        .m0_req(a_req[1][0]), .m0_rdata(fp_m0_rdata), .m0_done(fp_m0_done), .m0_err(fp_m0_err),
        .m1_addr(a_addr[1][1]), .m1_wdata(a_wdata[1][1]), .m1_write(a_wr[1][1]),
        .m1_req(a_req[1][1]), .m1_rdata(fp_m1_rdata), .m1_done(fp_m1_done), .m1_err(fp_m1_err),
        .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_write(fp_mem_write),
        .mem_req(fp_mem_req), .mem_rdata(mem_rdata[1]), .mem_done(mem_done[1]),
        .busy(fp_busy), .grant(fp_grant)
    );

    always_comb begin
        o_rdata[0][0] = rr_m0_rdata; o_rdata[0][1] = rr_m1_rdata;
        o_rdata[1][0] = fp_m0_rdata; o_rdata[1][1] = fp_m1_rdata;
        o_done[0][0]  = rr_m0_done;  o_done[0][1]  = rr_m1_done;
        o_done[1][0]  = fp_m0_done;  o_done[1][1]  = fp_m1_done;
        o_err[0][0]   = rr_m0_err;   o_err[0][1]   = rr_m1_err;
        o_err[1][0]   = fp_m0_err;   o_err[1][1]   = fp_m1_err;
        o_maddr[0] = rr_mem_addr;  o_maddr[1] = fp_mem_addr;
        o_mwd[0]   = rr_mem_wdata; o_mwd[1]   = fp_mem_wdata;
        o_mwr[0]   = rr_mem_write; o_mwr[1]   = fp_mem_write;
        o_mreq[0]  = rr_mem_req;   o_mreq[1]  = fp_mem_req;
        o_busy[0]  = rr_busy;      o_busy[1]  = fp_busy;
        o_grant[0] = rr_grant;     o_grant[1] = fp_grant;
    end

    function automatic logic [7:0] hash(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
    endfunction

    // Memory: registered done one cycle after req, unless withheld; garbage data otherwise
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            mem_done[k]  <= (o_mreq[k] && !withhold[k]) || inject[k];
            mem_rdata[k] <= use_lit[k] ? lit[k] :
                            (o_mreq[k] ? hash(o_maddr[k]) : 8'($urandom));
        end
    end

    task automatic chk(input string nm, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d t=%0t act=%h exp=%h", nm, k, $time, act, exp);
        end
    endtask

    // Transaction-level model: one active transfer per arbiter, aged from its issue cycle
    bit m_active [2];
    int m_port   [2];
    int m_age    [2];
    bit m_grant  [2];
    bit m_last   [2];
    bit m_dflag  [2][2];

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int tmo;
            int p;
            int np;
            logic e_busy, e_req, e_wr, e_done, e_err, e_grant;
            logic [15:0] e_addr;
            logic [7:0] e_wd, e_rd;
            tmo = (k == 0) ? T0 : T1;
            p = m_port[k];
            e_busy = 0; e_req = 0; e_wr = 0; e_done = 0; e_err = 0;
            e_rd = 8'h00; e_grant = m_grant[k];
            e_addr = a_addr[k][0]; e_wd = a_wdata[k][0];
            if (rst) begin
                e_grant = 0; e_addr = 16'h0000; e_wd = 8'h00;
            end else if (m_active[k]) begin
                e_busy = 1;
                e_addr = a_addr[k][p];
                e_wd = a_wdata[k][p];
                if (m_age[k] == 0) begin
                    e_req = 1;
                    e_wr = a_wr[k][p];
                end else if (mem_done[k]) begin
                    e_done = 1;
                    e_rd = mem_rdata[k];
                end else if (m_age[k] == tmo) begin
                    e_done = 1;
                    e_err = 1;
                end
            end
            chk("ctrl", k, {28'd0, o_busy[k], o_grant[k], o_mreq[k], o_mwr[k]},
                {28'd0, e_busy, e_grant, e_req, e_wr});
            chk("bus", k, {8'd0, o_maddr[k], o_mwd[k]}, {8'd0, e_addr, e_wd});
            for (int q = 0; q < 2; q++) begin
                logic [31:0] ev;
                ev = (e_done && p == q) ? {22'd0, e_done, e_err, e_rd} : 32'd0;
                chk(q == 0 ? "port0" : "port1", k,
                    {22'd0, o_done[k][q], o_err[k][q], o_rdata[k][q]}, ev);
                m_dflag[k][q] = e_done && (p == q);
            end
            if (rst) begin
                m_active[k] = 0; m_grant[k] = 0; m_last[k] = 1;
            end else if (!m_active[k]) begin
                if (a_req[k][0] || a_req[k][1]) begin
                    if (a_req[k][0] && a_req[k][1])
                        np = (k == 1) ? 0 : (m_last[k] ? 0 : 1);
                    else
                        np = a_req[k][1] ? 1 : 0;
                    m_active[k] = 1; m_age[k] = 0; m_port[k] = np;
                    m_grant[k] = (np == 1); m_last[k] = (np == 1);
                end
            end else if (e_done) begin
                m_active[k] = 0;
            end else begin
                m_age[k]++;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_step();
        end
    end

    task automatic new_txn(input int k, input int p);
        a_addr[k][p]  = 16'($urandom);
        a_wdata[k][p] = 8'($urandom);
        a_wr[k][p]    = 1'($urandom);
        a_req[k][p]   = 1'b1;
    endtask

    task automatic run_random(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 299) == 0);
            for (int k = 0; k < 2; k++) begin
                withhold[k] = ($urandom_range(0, 9) == 0);
                inject[k]   = ($urandom_range(0, 19) == 0);
                for (int p = 0; p < 2; p++) begin
                    if (rst) a_req[k][p] = 1'b0;
                    else if (a_req[k][p]) begin
                        if (m_dflag[k][p]) begin
                            if ($urandom_range(0, 1) == 1) new_txn(k, p);
                            else a_req[k][p] = 1'b0;
                        end
                    end else if ($urandom_range(0, 2) == 0) new_txn(k, p);
                end
            end
        end
    endtask

    int seq_rr[$];
    int seq_fp[$];
    int n, got, c0, c1, v;
    int iss[2];
    int dn[2];
    logic derr[2];
    logic [7:0] drd[2];

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            withhold[k] = 0; inject[k] = 0; use_lit[k] = 0; lit[k] = 8'h00;
            for (int p = 0; p < 2; p++) begin
                a_addr[k][p] = 16'h0000; a_wdata[k][p] = 8'h00;
                a_wr[k][p] = 1'b0; a_req[k][p] = 1'b0;
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 0, 32'(rr_busy), 0);
        chk("rst_grant", 1, 32'(fp_grant), 0);
        chk("rst_mreq", 0, 32'(rr_mem_req), 0);
        @(posedge clk); #1 rst = 1'b0;

        // m0 read of 0x0010
        use_lit[0] = 1; lit[0] = 8'hA5;
        a_addr[0][0] = 16'h0010; a_wr[0][0] = 0; a_req[0][0] = 1;
        @(negedge clk); chk("t1_idle_req", 0, 32'(rr_mem_req), 0);
        @(negedge clk); chk("t1_issue_req", 0, 32'(rr_mem_req), 1);
        chk("t1_issue_addr", 0, 32'(rr_mem_addr), 32'h0010);
        @(negedge clk); chk("t1_done", 0, 32'(rr_m0_done), 1);
        chk("t1_rdata", 0, 32'(rr_m0_rdata), 32'hA5);
        chk("t1_m1_done", 0, 32'(rr_m1_done), 0);
        chk("t1_wait_req", 0, 32'(rr_mem_req), 0);
        @(posedge clk); #1 a_req[0][0] = 0; use_lit[0] = 0;
        @(posedge clk); #1;

        // m1 write 0x0021 <- 0x3C
        a_addr[0][1] = 16'h0021; a_wdata[0][1] = 8'h3C; a_wr[0][1] = 1; a_req[0][1] = 1;
        @(negedge clk); chk("t2_idle_wr", 0, 32'(rr_mem_write), 0);
        chk("t2_idle_addr", 0, 32'(rr_mem_addr), 32'h0010);
        @(negedge clk); chk("t2_addr", 0, 32'(rr_mem_addr), 32'h0021);
        chk("t2_wdata", 0, 32'(rr_mem_wdata), 32'h3C);
        chk("t2_write", 0, 32'(rr_mem_write), 1);
        @(negedge clk); chk("t2_done", 0, 32'(rr_m1_done), 1);
        chk("t2_wait_wr", 0, 32'(rr_mem_write), 0);
        chk("t2_m0_done", 0, 32'(rr_m0_done), 0);
        @(posedge clk); #1 a_req[0][1] = 0; a_wr[0][1] = 0;
        @(posedge clk); #1;

        // both ports held on both arbiters
        for (int k = 0; k < 2; k++) for (int p = 0; p < 2; p++) new_txn(k, p);
        n = 0;
        while ((seq_rr.size() < 6 || seq_fp.size() < 6) && n < 60) begin
            @(negedge clk); n++;
            if (rr_m0_done) seq_rr.push_back(0);
            if (rr_m1_done) seq_rr.push_back(1);
            if (fp_m0_done) seq_fp.push_back(0);
            if (fp_m1_done) seq_fp.push_back(1);
        end
        for (int i = 0; i < 6; i++) begin
            v = (i < seq_rr.size()) ? seq_rr[i] : 99;
            chk("t3_rr_seq", 0, 32'(v), 32'(i % 2));
            v = (i < seq_fp.size()) ? seq_fp[i] : 99;
            chk("t3_fp_seq", 1, 32'(v), 0);
        end
        @(posedge clk); #1 a_req[1][0] = 0; a_req[0][0] = 0; a_req[0][1] = 0;
        n = 0; got = -1;
        while (got < 0 && n < 10) begin
            @(negedge clk); n++;
            if (fp_m0_done) got = 0;
            else if (fp_m1_done) got = 1;
        end
        chk("t3_fp_port1", 1, 32'(got), 1);
        @(posedge clk); #1 a_req[1][1] = 0;
        repeat (3) @(posedge clk);
        #1;

        // watchdog: memory never answers
        for (int k = 0; k < 2; k++) begin
            withhold[k] = 1; iss[k] = -1; dn[k] = -1; derr[k] = 0; drd[k] = 8'hFF;
            a_addr[k][0] = 16'($urandom); a_wr[k][0] = 0; a_req[k][0] = 1;
        end
        n = 0;
        while ((dn[0] < 0 || dn[1] < 0) && n < 40) begin
            @(negedge clk); n++;
            for (int k = 0; k < 2; k++) begin
                if (iss[k] < 0 && o_mreq[k]) iss[k] = n;
                if (dn[k] < 0 && o_done[k][0]) begin
                    dn[k] = n; derr[k] = o_err[k][0]; drd[k] = o_rdata[k][0];
                end
            end
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) if (dn[k] >= 0) a_req[k][0] = 0;
        end
        chk("t4_latency", 0, 32'(dn[0] - iss[0]), 32'(T0));
        chk("t4_latency", 1, 32'(dn[1] - iss[1]), 32'(T1));
        chk("t4_err", 0, 32'(derr[0]), 1);
        chk("t4_err", 1, 32'(derr[1]), 1);
        chk("t4_rdata", 0, 32'(drd[0]), 0);
        chk("t4_rdata", 1, 32'(drd[1]), 0);
        withhold[0] = 0; withhold[1] = 0;
        repeat (8) @(posedge clk);
        #1;

        // reset while waiting
        withhold[0] = 1; a_addr[0][0] = 16'h1234; a_req[0][0] = 1;
        repeat (3) @(negedge clk);
        chk("t5_busy_wait", 0, 32'(rr_busy), 1);
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        chk("t5_rst_busy", 0, 32'(rr_busy), 0);
        chk("t5_rst_addr", 0, 32'(rr_mem_addr), 0);
        chk("t5_rst_grant", 0, 32'(rr_grant), 0);
        @(posedge clk); #1 rst = 0; a_req[0][0] = 0; withhold[0] = 0; inject[0] = 1;
        @(posedge clk); #1 inject[0] = 0;
        repeat (3) begin
            @(negedge clk);
            chk("t5_late_done", 0, 32'(rr_m0_done), 0);
        end
        @(posedge clk); #1 new_txn(0, 0); new_txn(0, 1);
        n = 0; got = -1;
        while (got < 0 && n < 8) begin
            @(negedge clk); n++;
            if (rr_m0_done) got = 0;
            else if (rr_m1_done) got = 1;
        end
        chk("t5_tie_port0", 0, 32'(got), 0);
        @(posedge clk); #1 a_req[0][0] = 0; a_req[0][1] = 0;
        repeat (6) @(posedge clk);
        #1;

        // spurious done while idle, then back-to-back service
        inject[0] = 1; inject[1] = 1;
        repeat (4) begin
            @(negedge clk);
            chk("t6_spur_m0", 0, 32'(rr_m0_done), 0);
            chk("t6_spur_busy", 1, 32'(fp_busy), 0);
        end
        @(posedge clk); #1 inject[0] = 0; inject[1] = 0;
        repeat (2) @(posedge clk);
        #1 new_txn(0, 0);
        @(posedge clk); #1 new_txn(0, 1);
        c0 = -1; c1 = -1;
        for (int i = 1; i < 15; i++) begin
            @(negedge clk);
            if (c0 < 0 && rr_m0_done) c0 = i;
            if (c1 < 0 && rr_m1_done) c1 = i;
            @(posedge clk); #1;
            if (c0 >= 0) a_req[0][0] = 0;
            if (c1 >= 0) a_req[0][1] = 0;
        end
        chk("t6_m0_cycle", 0, 32'(c0), 2);
        chk("t6_m1_cycle", 0, 32'(c1), 5);

        run_random(3000);
        @(posedge clk); #1;
        rst = 0;
        for (int k = 0; k < 2; k++) begin
            withhold[k] = 0; inject[k] = 0;
            for (int p = 0; p < 2; p++) a_req[k][p] = 0;
        end
        repeat (40) @(posedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
